mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single main-memory port between I-cache line refills (fetch
//  side, stalls PC while !hit) and D-side accesses (D-cache refill or write-through).
//  Sequences multi-beat line refills, returns beats to the owning requester, pulses done.
//  Sits between the I/D caches and the memory model in the pipeline top level.
// PARAMETERS
//  ADDR_W          32  byte-address width
//  DATA_W          32  word width; beat stride = DATA_W/8 bytes
//  WORDS_PER_LINE  4   beats per refill burst; power of 2, >=2
// PORTS
//  clk        in   1       clock, all logic on posedge
//  rst        in   1       synchronous, active-high reset
//  i_req      in   1       I-side refill request; held until i_done
//  i_addr     in   ADDR_W  I-side miss address (any byte in line)
//  i_rdata    out  DATA_W  refill beat data
//  i_valid    out  1       i_rdata valid this cycle
//  i_beat     out  log2(WPL) beat index of i_rdata
//  i_done     out  1       1-cycle pulse: refill complete
//  d_req      in   1       D-side request; held until d_done
//  d_we       in   1       1 = single-word write, 0 = line refill
//  d_addr     in   ADDR_W  D-side address
//  d_wdata    in   DATA_W  write data (d_we=1)
//  d_rdata    out  DATA_W  refill beat data
//  d_valid    out  1       d_rdata valid
//  d_beat     out  log2(WPL) beat index of d_rdata
//  d_done     out  1       1-cycle pulse: access complete
//  mem_en     out  1       memory request active
//  mem_we     out  1       memory write strobe
//  mem_addr   out  ADDR_W  word address driven to memory
//  mem_wdata  out  DATA_W  write data to memory
//  mem_rdata  in   DATA_W  read data from memory
//  mem_ready  in   1       memory beat accepted/returned this cycle
// BEHAVIOUR
//  States: IDLE, I_RD, D_RD, D_WR, DONE.  Reset -> IDLE; all outputs 0.
//  IDLE: grant decision each cycle; d_req beats i_req (older instr in MEM).
//   d_req&d_we -> D_WR; d_req&!d_we -> D_RD; else i_req -> I_RD. Address
//   latched at grant; line base = addr with low log2(WPL*DATA_W/8) bits cleared.
//  I_RD/D_RD: mem_en=1, mem_we=0, mem_addr=base+beat*(DATA_W/8); beat ctr from 0.
//   On mem_ready: owner's rdata=mem_rdata, valid=1, beat=ctr same cycle; ctr++.
//   mem_ready on last beat (ctr==WPL-1) -> DONE. No mem_ready -> hold, no valid.
//  D_WR: mem_en=1, mem_we=1, mem_addr=d_addr word-aligned, mem_wdata=d_wdata;
//   mem_ready -> DONE. Exactly one beat.
//  DONE: owner's done=1 for exactly this cycle, mem_en=0; next state IDLE.
//   Requests ignored in DONE; requester drops req the cycle after done.
//  Grant latency: req seen in IDLE -> mem_en asserted next cycle. Min refill =
//   WPL+2 cycles from grant cycle to done pulse (mem_ready tied high).
//  Simultaneous i_req&d_req in IDLE: D granted; I waits, served after DONE.
//  Req dropped mid-burst: illegal; arbiter completes burst regardless.
//  Beat counter wraps to 0 on entering DONE; never exceeds WPL-1.
//  rst mid-burst: next cycle IDLE, ctr=0, outputs 0, partial line discarded, no done.
//  valid/done outputs are registered-free combinational decode of state+mem_ready;
//   rdata outputs are 0 when the matching valid is 0.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: 1-bit last-owner flag (reset = I); on simultaneous
//   i_req&d_req in IDLE the side NOT served last wins; flag updates in DONE.
//  Not defined: fixed priority D > I as above; no flag state.
// TESTING
//  i_req, i_addr=0x104, mem_ready=1 -> mem_addr 0x100,0x104,0x108,0x10C; i_valid
//   beats 0..3; i_done on cycle grant+5; d_* outputs stay 0.
//  d_req,d_we=1,d_addr=0x2002,d_wdata=0xDEADBEEF -> one cycle mem_we=1,
//   mem_addr=0x2000, mem_wdata=0xDEADBEEF; d_done next cycle.
//  i_req&d_req same cycle (d_we=0), no RR -> D refill completes first, then I
//   refill; with ARB_ROUND_ROBIN_EN after reset -> D first, repeated pair -> I next.
//  mem_ready low 3 cycles on beat 2 -> mem_addr held at beat 2, no valid,
//   burst resumes; done 3 cycles later than baseline.
//  rst pulsed during beat 1 of I refill -> IDLE next cycle, no i_done, mem_en=0;
//   re-issued i_req refills from beat 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between I-cache refills and D-side refills/writes.
// Optional ARB_ROUND_ROBIN_EN: alternate the winner on simultaneous requests.
//
// state | meaning
// IDLE  | no transfer; pick the next owner from i_req/d_req
// I_RD  | multi-beat line refill for the I-side
// D_RD  | multi-beat line refill for the D-side
// D_WR  | single-word D-side write-through
// DONE  | pulse the owner's done; requests ignored
module mem_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              i_req,
   input  logic [ADDR_W-1:0]                 i_addr,
   output logic [DATA_W-1:0]                 i_rdata,
   output logic                              i_valid,
   output logic [$clog2(WORDS_PER_LINE)-1:0] i_beat,
   output logic                              i_done,
   input  logic                              d_req,
   input  logic                              d_we,
   input  logic [ADDR_W-1:0]                 d_addr,
   input  logic [DATA_W-1:0]                 d_wdata,
   output logic [DATA_W-1:0]                 d_rdata,
   output logic                              d_valid,
   output logic [$clog2(WORDS_PER_LINE)-1:0] d_beat,
   output logic                              d_done,
   output logic                              mem_en,
   output logic                              mem_we,
   output logic [ADDR_W-1:0]                 mem_addr,
   output logic [DATA_W-1:0]                 mem_wdata,
   input  logic [DATA_W-1:0]                 mem_rdata,
   input  logic                              mem_ready
);

   localparam int BEAT_W = $clog2(WORDS_PER_LINE);
   localparam int SB     = $clog2(DATA_W/8);
   localparam int OFF_W  = BEAT_W + SB;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE-1);

   typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} state_t;

   state_t              state, state_nx;
   logic                owner_d;
   logic [ADDR_W-1:0]   base;
   logic [DATA_W-1:0]   wdata;
   logic [BEAT_W-1:0]   ctr;
   logic                grant_d;
   logic [ADDR_W-1:0]   beat_off;
   logic                unused_addr_bits;

   assign unused_addr_bits = ^{i_addr[OFF_W-1:0], d_addr[SB-1:0]};
   assign beat_off = {{(ADDR_W-BEAT_W){1'b0}}, ctr} << SB;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_d;

   // On a tie the side that was not served last wins.
   assign grant_d = d_req && !(i_req && last_d);

   always_ff @(posedge clk) begin
      if (rst)
         last_d <= 1'b0;
      else if (state == DONE)
         last_d <= owner_d;
   end
`else
   assign grant_d = d_req;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         owner_d <= 1'b0;
         base    <= '0;
         wdata   <= '0;
         ctr     <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && state_nx != IDLE) begin
            owner_d <= grant_d;
            wdata   <= d_wdata;
            ctr     <= '0;
            if (grant_d && d_we)
               base <= {d_addr[ADDR_W-1:SB], {SB{1'b0}}};
            else if (grant_d)
               base <= {d_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            else
               base <= {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
         end else if ((state == I_RD || state == D_RD) && mem_ready) begin
            ctr <= ctr + 1'b1;
         end
      end
   end

   always_comb begin
      state_nx  = state;
      i_rdata   = '0;
      i_valid   = 1'b0;
      i_beat    = '0;
      i_done    = 1'b0;
      d_rdata   = '0;
      d_valid   = 1'b0;
      d_beat    = '0;
      d_done    = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         IDLE: begin
            if (grant_d)
               state_nx = d_we ? D_WR : D_RD;
            else if (i_req)
               state_nx = I_RD;
         end
         I_RD: begin
            mem_en   = 1'b1;
            mem_addr = base | beat_off;
            if (mem_ready) begin
               i_valid = 1'b1;
               i_rdata = mem_rdata;
               i_beat  = ctr;
               if (ctr == LAST_BEAT)
                  state_nx = DONE;
            end
         end
         D_RD: begin
            mem_en   = 1'b1;
            mem_addr = base | beat_off;
            if (mem_ready) begin
               d_valid = 1'b1;
               d_rdata = mem_rdata;
               d_beat  = ctr;
               if (ctr == LAST_BEAT)
                  state_nx = DONE;
            end
         end
         D_WR: begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = base;
            mem_wdata = wdata;
            if (mem_ready)
               state_nx = DONE;
         end
         DONE: begin
            i_done   = !owner_d;
            d_done   = owner_d;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule
